// File: rtl/objective_pkg.sv
// Shared types and helpers for the training-loss stage.
//   activation_t : 8-bit perceptron result / label
//   error_t      : signed 16-bit error returned to the perceptron
//   state_t      : LOAD (collecting inputs) / EMIT (presenting outputs)
//   scale_error  : saturating arithmetic left shift of a 9-bit signed difference
package objective_pkg;

  typedef logic [7:0]         activation_t;
  typedef logic signed [15:0] error_t;
  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  // Shift is 0..8, so 9 + 8 = 17 magnitude bits plus sign fits in 18 bits
  // without overflow before saturation.
  function automatic error_t scale_error(input logic signed [8:0] diff,
                                         input int unsigned       shift);
    logic signed [17:0] wide;
    wide = {{9{diff[8]}}, diff};
    wide = wide <<< shift;
    if (wide > 18'sd32767)       return 16'sh7FFF;
    else if (wide < -18'sd32768) return 16'sh8000;
    else                         return error_t'(wide[15:0]);
  endfunction

endpackage

// File: rtl/objective_counter_sat.sv
// W-bit saturating up-counter.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : synchronous clear, wins over enable
//   enable       : increment request (ignored once count is all-ones)
//   count        : current value
module counter_sat #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear)            count <= '0;
    else if (enable && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/objective.sv
// Training-loss stage behind the perceptron. Accepts a result (argument),
// forwards it to the sink, and in training mode pairs it with a label
// (target) to produce a scaled signed error for the perceptron.
//   argument_*  : perceptron result in (valid/ready)
//   target_*    : label in (valid/ready), only accepted while train is high
//   result_*    : forwarded result out
//   error_*     : scaled error out (training samples only)
//   train       : mode, latched at the argument handshake
//   clear       : clears the mistake counter
//   mistakes    : saturating count of training samples with nonzero error
module objective
  import objective_pkg::*;
#(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         train,
  input  logic         clear,
  input  logic         argument_valid,
  input  logic [7:0]   argument_data,
  output logic         argument_ready,
  input  logic         target_valid,
  input  logic [7:0]   target_data,
  output logic         target_ready,
  output logic         result_valid,
  output logic [7:0]   result_data,
  input  logic         result_ready,
  output logic         error_valid,
  output logic [15:0]  error_data,
  input  logic         error_ready,
  output logic [W-1:0] mistakes
);

  state_t           state, state_n;
  activation_t      arg_q, tgt_q, arg_eff, tgt_eff;
  logic             have_arg, have_tgt, mode, mode_eff;
  logic             arg_take, tgt_take, go, done, rv_n, ev_n;
  logic signed [8:0] diff;

  assign argument_ready = !reset && state == LOAD && !have_arg;
  assign target_ready   = !reset && state == LOAD && train && !have_tgt;
  assign arg_take       = argument_valid && argument_ready;
  assign tgt_take       = target_valid && target_ready;

  // Look through this cycle's handshakes so the outputs load on the same edge
  // as the last input handshake (one cycle of latency).
  assign mode_eff = arg_take ? train         : mode;
  assign arg_eff  = arg_take ? argument_data : arg_q;
  assign tgt_eff  = tgt_take ? target_data   : tgt_q;
  assign diff     = $signed({1'b0, tgt_eff}) - $signed({1'b0, arg_eff});

  // Valids that remain after this cycle's output handshakes.
  assign rv_n = result_valid && !result_ready;
  assign ev_n = error_valid && !error_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    done    = 1'b0;
    case (state)
      LOAD: if ((have_arg || arg_take) && (!mode_eff || have_tgt || tgt_take)) begin
        go      = 1'b1;
        state_n = EMIT;
      end
      EMIT: if (!rv_n && !ev_n) begin
        done    = 1'b1;
        state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arg_q        <= '0;
      tgt_q        <= '0;
      have_arg     <= 1'b0;
      have_tgt     <= 1'b0;
      mode         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      error_valid  <= 1'b0;
      error_data   <= '0;
    end else begin
      if (arg_take) begin
        arg_q    <= argument_data;
        have_arg <= 1'b1;
        mode     <= train;
      end
      if (tgt_take) begin
        tgt_q    <= target_data;
        have_tgt <= 1'b1;
      end
      if (go) begin
        result_valid <= 1'b1;
        result_data  <= arg_eff;
        // An inference sample leaves any waiting label for the next training sample.
        if (mode_eff) begin
          error_valid <= 1'b1;
          error_data  <= scale_error(diff, SHIFT);
          have_tgt    <= 1'b0;
        end
      end
      if (state == EMIT) begin
        result_valid <= rv_n;
        error_valid  <= ev_n;
        if (done) have_arg <= 1'b0;
      end
    end
  end

  counter_sat #(.W(W)) u_mistakes (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (go && mode_eff && diff != 9'sd0),
    .count  (mistakes)
  );

endmodule

// File: tb/tb_objective.sv
// Directed bench for objective: one default instance (SHIFT=4, W=16) and one
// SHIFT=8, W=2 instance sharing the same inputs for saturation checks.
module tb_objective;

  logic        clock = 1'b0;
  logic        reset, train, clear;
  logic        argument_valid, target_valid, result_ready, error_ready;
  logic [7:0]  argument_data, target_data;
  logic        argument_ready, target_ready, result_valid, error_valid;
  logic [7:0]  result_data;
  logic [15:0] error_data;
  logic [15:0] mistakes;
  logic        argument_ready8, target_ready8, result_valid8, error_valid8;
  logic [7:0]  result_data8;
  logic [15:0] error_data8;
  logic [1:0]  mistakes8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  objective #(.SHIFT(4), .W(16)) dut (
    .clock(clock), .reset(reset), .train(train), .clear(clear),
    .argument_valid(argument_valid), .argument_data(argument_data), .argument_ready(argument_ready),
    .target_valid(target_valid), .target_data(target_data), .target_ready(target_ready),
    .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
    .error_valid(error_valid), .error_data(error_data), .error_ready(error_ready),
    .mistakes(mistakes)
  );

  objective #(.SHIFT(8), .W(2)) dut8 (
    .clock(clock), .reset(reset), .train(train), .clear(clear),
    .argument_valid(argument_valid), .argument_data(argument_data), .argument_ready(argument_ready8),
    .target_valid(target_valid), .target_data(target_data), .target_ready(target_ready8),
    .result_valid(result_valid8), .result_data(result_data8), .result_ready(result_ready),
    .error_valid(error_valid8), .error_data(error_data8), .error_ready(error_ready),
    .mistakes(mistakes8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; train = 1'b1; clear = 1'b0;
    argument_valid = 1'b0; argument_data = 8'h00;
    target_valid = 1'b0; target_data = 8'h00;
    result_ready = 1'b1; error_ready = 1'b1;
    tick(); tick();
    chk("rst_arg_ready", argument_ready, 0);
    chk("rst_tgt_ready", target_ready, 0);
    chk("rst_res_valid", result_valid, 0);
    chk("rst_err_valid", error_valid, 0);
    chk("rst_res_data", result_data, 0);
    chk("rst_err_data", error_data, 0);
    chk("rst_mistakes", mistakes, 0);
    reset = 1'b0; train = 1'b0; #1;
    chk("post_rst_arg_ready", argument_ready, 1);

    // Inference, 0xFF
    argument_valid = 1'b1; argument_data = 8'hFF;
    tick();
    argument_valid = 1'b0;
    chk("inf_res_valid", result_valid, 1);
    chk("inf_res_data", result_data, 8'hFF);
    chk("inf_err_valid", error_valid, 0);
    chk("inf_arg_ready", argument_ready, 0);
    tick();
    chk("inf_done_valid", result_valid, 0);
    chk("inf_mistakes", mistakes, 0);
    chk("inf_arg_ready_back", argument_ready, 1);

    // Train, arg 0xFF and target 0x00 together: -255<<4 = -4080
    train = 1'b1; argument_valid = 1'b1; argument_data = 8'hFF;
    target_valid = 1'b1; target_data = 8'h00; #1;
    chk("t1_tgt_ready", target_ready, 1);
    tick();
    argument_valid = 1'b0; target_valid = 1'b0;
    chk("t1_res_valid", result_valid, 1);
    chk("t1_res_data", result_data, 8'hFF);
    chk("t1_err_valid", error_valid, 1);
    chk("t1_err_data", error_data, 16'hF010);
    chk("t1_mistakes", mistakes, 1);
    tick();
    chk("t1_done", {result_valid, error_valid}, 0);

    // Target 0xFF three cycles ahead of argument 0x00: 255<<4 = 0x0FF0
    target_valid = 1'b1; target_data = 8'hFF;
    tick();
    target_valid = 1'b0;
    chk("t2_tgt_ready_held", target_ready, 0);
    chk("t2_wait_res_valid", result_valid, 0);
    tick(); tick();
    argument_valid = 1'b1; argument_data = 8'h00;
    tick();
    argument_valid = 1'b0;
    chk("t2_res_valid", result_valid, 1);
    chk("t2_err_data", error_data, 16'h0FF0);
    chk("t2_mistakes", mistakes, 2);
    chk("t2_arg_ready_emit", argument_ready, 0);
    tick();

    // Equal argument and target: zero error still delivered, no mistake
    argument_valid = 1'b1; argument_data = 8'hFF;
    target_valid = 1'b1; target_data = 8'hFF;
    tick();
    argument_valid = 1'b0; target_valid = 1'b0;
    chk("t3_err_valid", error_valid, 1);
    chk("t3_err_data", error_data, 0);
    chk("t3_mistakes", mistakes, 2);
    tick();

    // Backpressure: 0x34-0x12 = 34, <<4 = 0x0220
    argument_valid = 1'b1; argument_data = 8'h12;
    target_valid = 1'b1; target_data = 8'h34;
    result_ready = 1'b0; error_ready = 1'b0;
    tick();
    target_valid = 1'b0; argument_data = 8'h56;  // new argument offered during EMIT
    chk("bp_res_data", result_data, 8'h12);
    chk("bp_err_data", error_data, 16'h0220);
    chk("bp_mistakes", mistakes, 3);
    tick();
    chk("bp_stable", {result_valid, error_valid, result_data, error_data}, {2'b11, 8'h12, 16'h0220});
    chk("bp_arg_ready_0", argument_ready, 0);
    result_ready = 1'b1;
    tick();
    chk("bp_res_done", {result_valid, error_valid}, 2'b01);
    chk("bp_err_hold", error_data, 16'h0220);
    chk("bp_arg_ready_1", argument_ready, 0);
    tick(); tick();
    chk("bp_err_still", error_valid, 1);
    error_ready = 1'b1;
    tick();
    chk("bp_all_done", {result_valid, error_valid}, 0);
    chk("bp_load", argument_ready, 1);
    argument_valid = 1'b0;

    // Label retained across an inference sample
    target_valid = 1'b1; target_data = 8'h10;
    tick();
    target_valid = 1'b0; train = 1'b0;
    argument_valid = 1'b1; argument_data = 8'h20;
    tick();
    argument_valid = 1'b0;
    chk("ret_inf", {result_valid, error_valid, result_data}, {2'b10, 8'h20});
    tick();
    train = 1'b1; argument_valid = 1'b1; argument_data = 8'h10;
    tick();
    argument_valid = 1'b0;
    chk("ret_err_valid", error_valid, 1);
    chk("ret_err_data", error_data, 0);
    chk("ret_mistakes", mistakes, 3);
    tick();

    // SHIFT=8 saturation and W=2 counter saturation
    argument_valid = 1'b1; argument_data = 8'h00;
    target_valid = 1'b1; target_data = 8'hFF;
    tick();
    argument_valid = 1'b0; target_valid = 1'b0;
    chk("s8_err_data", error_data8, 16'h7FFF);
    chk("s4_err_data", error_data, 16'h0FF0);
    chk("s4_mistakes", mistakes, 4);
    chk("w2_mistakes_sat", mistakes8, 2'b11);
    tick();

    // Clear in the same cycle as a mistake
    argument_valid = 1'b1; argument_data = 8'h00;
    target_valid = 1'b1; target_data = 8'h01; clear = 1'b1;
    tick();
    argument_valid = 1'b0; target_valid = 1'b0; clear = 1'b0;
    chk("clr_mistakes", mistakes, 0);
    chk("clr_err_data", error_data, 16'h0010);
    tick();
    chk("clr_stays", mistakes, 0);

    // Reset during EMIT
    argument_valid = 1'b1; argument_data = 8'h05;
    target_valid = 1'b1; target_data = 8'h07;
    result_ready = 1'b0; error_ready = 1'b0;
    tick();
    argument_valid = 1'b0; target_valid = 1'b0;
    chk("re_emit", {result_valid, error_valid, mistakes}, {2'b11, 16'd1});
    reset = 1'b1;
    tick();
    chk("re_valids", {result_valid, error_valid}, 0);
    chk("re_mistakes", mistakes, 0);
    chk("re_arg_ready", argument_ready, 0);
    reset = 1'b0; #1;
    chk("re_arg_ready_after", argument_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
